ex_muldiv_stage: RTL and testbench

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

---
 rtl/ex_muldiv_stage.sv | 190 +++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: MIPS EX stage with a single-cycle ALU/shifter, a HI/LO
// register pair and an iterative radix-2 multiply/divide unit.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   valid_in, flush              live instruction in EX / abort in-flight op
//   funct, shamt                 R-type function code, immediate shift amount
//   operand_1, operand_2         rs, rt source operands
//   reg_write_en_in/addr_in      writeback control from ID
//   mem_write_flag_in            instruction is a store (no register write)
//   reg_write_en_out/addr_out    writeback control to MEM
//   result                       ALU / move-from-HI/LO result
//   stall_req                    hold EX and earlier stages
//   md_busy                      iterative unit is not idle
module ex_muldiv_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic                   flush,
  input  logic [5:0]             funct,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  operand_1,
  input  logic [DATA_WIDTH-1:0]  operand_2,
  input  logic                   reg_write_en_in,
  input  logic [4:0]             reg_write_addr_in,
  input  logic                   mem_write_flag_in,
  output logic                   reg_write_en_out,
  output logic [4:0]             reg_write_addr_out,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   stall_req,
  output logic                   md_busy
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JALR = 6'h09, F_MFHI = 6'h10, F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic [W-1:0]     hi, lo;
  // acc_hi/acc_lo: {partial product, multiplier} or {remainder, quotient}
  logic [W-1:0]     acc_hi, acc_lo, op_b;
  logic             is_div, neg_q, neg_r, div_zero;

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B; bit1 selects divide, bit0 unsigned.
  logic is_md, md_start, signed_op, a_neg, b_neg, mt_ok;
  logic [W-1:0] mag_a, mag_b;
  logic [SHAMT_WIDTH-1:0] var_sh;

  assign is_md     = (funct[5:2] == 4'b0110);
  assign md_start  = (state == IDLE) && valid_in && is_md && !flush;
  assign signed_op = !funct[0];
  assign a_neg     = signed_op && operand_1[W-1];
  assign b_neg     = signed_op && operand_2[W-1];
  assign mag_a     = a_neg ? -operand_1 : operand_1;
  assign mag_b     = b_neg ? -operand_2 : operand_2;
  assign var_sh    = operand_1[SHAMT_WIDTH-1:0];

  assign stall_req = !flush && (((state == IDLE) && valid_in && is_md) || (state == BUSY));
  assign md_busy   = (state != IDLE);
  assign mt_ok     = valid_in && !flush && !stall_req;

  assign reg_write_en_out   = !is_md && reg_write_en_in && !mem_write_flag_in && valid_in;
  assign reg_write_addr_out = reg_write_addr_in;

  // One radix-2 iteration: shift-add for multiply, restoring step for divide.
  logic [W:0]   add_sum, div_shift;
  logic [W-1:0] div_diff, nxt_hi, nxt_lo;
  logic         div_ge;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, op_b});
    div_diff  = div_shift[W-1:0] - op_b;
    nxt_hi    = add_sum[W:1];
    nxt_lo    = {add_sum[0], acc_lo[W-1:1]};
    if (is_div) begin
      nxt_hi = div_ge ? div_diff : div_shift[W-1:0];
      nxt_lo = {acc_lo[W-2:0], div_ge};
    end
  end

  // Sign correction of the magnitude result; divide by zero bypasses the
  // quotient fix-up (remainder already equals the dividend after W steps).
  logic [2*W-1:0] prod_raw, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  assign prod_raw = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign quot_fix = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      op_b     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state    <= BUSY;
            counter  <= CNT_W'(DATA_WIDTH - 1);
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            op_b     <= mag_b;
            is_div   <= funct[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (operand_2 == '0);
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (counter == '0) state <= DONE;
            else               counter <= counter - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // HI/LO: iterative result commits on the DONE->IDLE edge; MTHI/MTLO otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if ((state == DONE) && !flush) begin
      hi <= is_div ? rem_fix  : prod_fix[2*W-1:W];
      lo <= is_div ? quot_fix : prod_fix[W-1:0];
    end else if (mt_ok && (funct == F_MTHI)) begin
      hi <= operand_1;
    end else if (mt_ok && (funct == F_MTLO)) begin
      lo <= operand_1;
    end
  end

  always_comb begin
    result = '0;
    case (funct)
      F_ADD, F_ADDU: result = operand_1 + operand_2;
      F_SUB, F_SUBU: result = operand_1 - operand_2;
      F_AND:         result = operand_1 & operand_2;
      F_OR, F_JALR:  result = operand_1 | operand_2;
      F_XOR:         result = operand_1 ^ operand_2;
      F_NOR:         result = ~(operand_1 | operand_2);
      F_SLT:         result = {{(W-1){1'b0}}, ($signed(operand_1) < $signed(operand_2))};
      F_SLTU:        result = {{(W-1){1'b0}}, (operand_1 < operand_2)};
      F_SLL:         result = operand_2 << shamt;
      F_SRL:         result = operand_2 >> shamt;
      F_SRA:         result = $unsigned($signed(operand_2) >>> shamt);
      F_SLLV:        result = operand_2 << var_sh;
      F_SRLV:        result = operand_2 >> var_sh;
      F_SRAV:        result = $unsigned($signed(operand_2) >>> var_sh);
      F_MFHI:        result = hi;
      F_MFLO:        result = lo;
      default:       result = '0;
    endcase
  end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed testbench for ex_muldiv_stage: a 32-bit instance for the main
// scenarios and a 16-bit instance for the narrow-width multiply.
module tb_ex_muldiv_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          valid_in, flush, reg_write_en_in, mem_write_flag_in;
  logic [5:0]    funct;
  logic [4:0]    shamt, reg_write_addr_in, reg_write_addr_out;
  logic [W-1:0]  operand_1, operand_2, result;
  logic          reg_write_en_out, stall_req, md_busy;

  logic          v16, fl16, we_in16, mem16, we16, stall16, busy16;
  logic [5:0]    f16;
  logic [3:0]    s16;
  logic [4:0]    wa_in16, wa16;
  logic [15:0]   a16, b16, r16;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_stage #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
    .funct(funct), .shamt(shamt), .operand_1(operand_1), .operand_2(operand_2),
    .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
    .mem_write_flag_in(mem_write_flag_in), .reg_write_en_out(reg_write_en_out),
    .reg_write_addr_out(reg_write_addr_out), .result(result),
    .stall_req(stall_req), .md_busy(md_busy)
  );

  ex_muldiv_stage #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .valid_in(v16), .flush(fl16),
    .funct(f16), .shamt(s16), .operand_1(a16), .operand_2(b16),
    .reg_write_en_in(we_in16), .reg_write_addr_in(wa_in16),
    .mem_write_flag_in(mem16), .reg_write_en_out(we16),
    .reg_write_addr_out(wa16), .result(r16),
    .stall_req(stall16), .md_busy(busy16)
  );

  // Present one instruction on the 32-bit instance at the falling edge.
  task automatic drive(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sa);
    @(negedge clk);
    valid_in  = 1'b1;
    funct     = f;
    operand_1 = a;
    operand_2 = b;
    shamt     = sa;
    #1;
  endtask

  // Count consecutive stall cycles from the current one, bounded at 100.
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stall_req) break;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (stall_req !== 1'b0 || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags stall=%b busy=%b required 0 0", stall_req, md_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'h10, '0, '0, '0);
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL reset_hi got %h required 0", result);
    end
    drive(6'h12, '0, '0, '0);
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL reset_lo got %h required 0", result);
    end
  endtask

  task automatic test_alu;
    logic [5:0]   f [15];
    logic [31:0]  a [15];
    logic [31:0]  b [15];
    logic [4:0]   s [15];
    logic [31:0]  e [15];
    f[0]=6'h22;  a[0]=32'd5;          b[0]=32'd7;          s[0]=0; e[0]=32'hFFFFFFFE;
    f[1]=6'h2A;  a[1]=32'hFFFFFFFF;   b[1]=32'd1;          s[1]=0; e[1]=32'd1;
    f[2]=6'h2B;  a[2]=32'hFFFFFFFF;   b[2]=32'd1;          s[2]=0; e[2]=32'd0;
    f[3]=6'h03;  a[3]=32'd0;          b[3]=32'h80000000;   s[3]=4; e[3]=32'hF8000000;
    f[4]=6'h20;  a[4]=32'h7FFFFFFF;   b[4]=32'd1;          s[4]=0; e[4]=32'h80000000;
    f[5]=6'h27;  a[5]=32'd0;          b[5]=32'd0;          s[5]=0; e[5]=32'hFFFFFFFF;
    f[6]=6'h06;  a[6]=32'd4;          b[6]=32'hF0;         s[6]=0; e[6]=32'h0000000F;
    f[7]=6'h00;  a[7]=32'd9;          b[7]=32'hDEADBEEF;   s[7]=0; e[7]=32'hDEADBEEF;
    f[8]=6'h09;  a[8]=32'h100;        b[8]=32'h1;          s[8]=0; e[8]=32'h101;
    f[9]=6'h3F;  a[9]=32'd5;          b[9]=32'd5;          s[9]=0; e[9]=32'd0;
    f[10]=6'h07; a[10]=32'h24;        b[10]=32'h80000000;  s[10]=0; e[10]=32'hF8000000;
    f[11]=6'h26; a[11]=32'hFF00;      b[11]=32'h0FF0;      s[11]=0; e[11]=32'hF0F0;
    f[12]=6'h2A; a[12]=32'd1;         b[12]=32'hFFFFFFFF;  s[12]=0; e[12]=32'd0;
    f[13]=6'h2B; a[13]=32'd1;         b[13]=32'hFFFFFFFF;  s[13]=0; e[13]=32'd1;
    f[14]=6'h02; a[14]=32'd0;         b[14]=32'h80000000;  s[14]=31; e[14]=32'd1;
    reg_write_en_in   = 1'b1;
    mem_write_flag_in = 1'b0;
    reg_write_addr_in = 5'd17;
    for (int i = 0; i < 15; i++) begin
      drive(f[i], a[i], b[i], s[i]);
      checks++;
      if (result !== e[i]) begin
        failures++;
        $display("FAIL alu_%0d funct=%h got %h required %h", i, f[i], result, e[i]);
      end
      checks++;
      if (reg_write_en_out !== 1'b1 || reg_write_addr_out !== 5'd17) begin
        failures++;
        $display("FAIL alu_wb_%0d got en=%b addr=%0d required 1 17", i, reg_write_en_out, reg_write_addr_out);
      end
    end
    mem_write_flag_in = 1'b1;
    drive(6'h21, 32'd1, 32'd2, 0);
    checks++;
    if (reg_write_en_out !== 1'b0 || result !== 32'd3) begin
      failures++;
      $display("FAIL alu_store got en=%b res=%h required 0 3", reg_write_en_out, result);
    end
    mem_write_flag_in = 1'b0;
  endtask

  task automatic test_mult;
    int n;
    drive(6'h18, 32'hFFFFFFFE, 32'd3, 0);
    checks++;
    if (result !== 32'h0 || reg_write_en_out !== 1'b0) begin
      failures++;
      $display("FAIL mult_wb got res=%h en=%b required 0 0", result, reg_write_en_out);
    end
    count_stalls(n);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL mult_stalls got %0d required 33", n);
    end
    checks++;
    if (md_busy !== 1'b1) begin
      failures++;
      $display("FAIL mult_done_busy got %b required 1", md_busy);
    end
    drive(6'h10, '0, '0, 0);
    checks++;
    if (result !== 32'hFFFFFFFF || md_busy !== 1'b0) begin
      failures++;
      $display("FAIL mult_hi got %h busy=%b required ffffffff 0", result, md_busy);
    end
    drive(6'h12, '0, '0, 0);
    checks++;
    if (result !== 32'hFFFFFFFA) begin
      failures++;
      $display("FAIL mult_lo got %h required fffffffa", result);
    end
  endtask

  task automatic test_div;
    int n;
    drive(6'h1A, 32'hFFFFFFF9, 32'd2, 0);
    count_stalls(n);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL div_stalls got %0d required 33", n);
    end
    drive(6'h10, '0, '0, 0);
    checks++;
    if (result !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL div_hi got %h required ffffffff", result);
    end
    drive(6'h12, '0, '0, 0);
    checks++;
    if (result !== 32'hFFFFFFFD) begin
      failures++;
      $display("FAIL div_lo got %h required fffffffd", result);
    end
    drive(6'h1B, 32'd7, 32'd0, 0);
    count_stalls(n);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL divu0_stalls got %0d required 33", n);
    end
    drive(6'h10, '0, '0, 0);
    checks++;
    if (result !== 32'd7) begin
      failures++;
      $display("FAIL divu0_hi got %h required 7", result);
    end
    drive(6'h12, '0, '0, 0);
    checks++;
    if (result !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL divu0_lo got %h required ffffffff", result);
    end
  endtask

  // HI=7, LO=ffffffff on entry; a flushed MULTU must leave them intact.
  task automatic test_flush;
    drive(6'h19, 32'd3, 32'd4, 0);
    for (int k = 1; k < 10; k++) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0 || md_busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle got stall=%b busy=%b required 0 1", stall_req, md_busy);
    end
    @(negedge clk);
    flush    = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got busy=%b required 0", md_busy);
    end
    drive(6'h10, '0, '0, 0);
    checks++;
    if (result !== 32'd7) begin
      failures++;
      $display("FAIL flush_hi got %h required 7", result);
    end
    drive(6'h12, '0, '0, 0);
    checks++;
    if (result !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL flush_lo got %h required ffffffff", result);
    end
  endtask

  task automatic test_move;
    drive(6'h11, 32'hABCD, '0, 0);
    flush = 1'b1;
    #1;
    drive(6'h10, '0, '0, 0);
    flush = 1'b0;
    #1;
    checks++;
    if (result !== 32'd7) begin
      failures++;
      $display("FAIL mthi_flushed got %h required 7", result);
    end
    drive(6'h11, 32'hABCD, '0, 0);
    drive(6'h10, '0, '0, 0);
    checks++;
    if (result !== 32'hABCD) begin
      failures++;
      $display("FAIL mthi_back_to_back got %h required abcd", result);
    end
  endtask

  task automatic test_reset_mid;
    drive(6'h1B, 32'd100, 32'd3, 0);
    repeat (5) @(negedge clk);
    #2;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got busy=%b stall=%b required 0 0", md_busy, stall_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'h10, '0, '0, 0);
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_hi got %h required 0", result);
    end
    drive(6'h12, '0, '0, 0);
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_lo got %h required 0", result);
    end
    drive(6'h13, 32'h1234, '0, 0);
    drive(6'h12, '0, '0, 0);
    checks++;
    if (result !== 32'h1234) begin
      failures++;
      $display("FAIL mtlo_mflo got %h required 1234", result);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_w16;
    int n;
    @(negedge clk);
    v16 = 1'b1;
    f16 = 6'h18;
    a16 = 16'h8000;
    b16 = 16'h8000;
    #1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stall16) break;
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n !== 17) begin
      failures++;
      $display("FAIL w16_stalls got %0d required 17", n);
    end
    @(negedge clk);
    f16 = 6'h10;
    #1;
    checks++;
    if (r16 !== 16'h4000) begin
      failures++;
      $display("FAIL w16_hi got %h required 4000", r16);
    end
    @(negedge clk);
    f16 = 6'h12;
    #1;
    checks++;
    if (r16 !== 16'h0000) begin
      failures++;
      $display("FAIL w16_lo got %h required 0000", r16);
    end
    v16 = 1'b0;
  endtask

  initial begin
    valid_in = 0; flush = 0; funct = 6'h3F; shamt = 0;
    operand_1 = '0; operand_2 = '0;
    reg_write_en_in = 0; reg_write_addr_in = 0; mem_write_flag_in = 0;
    v16 = 0; fl16 = 0; f16 = 6'h3F; s16 = 0; a16 = 0; b16 = 0;
    we_in16 = 0; wa_in16 = 0; mem16 = 0;
    test_reset;
    test_alu;
    test_mult;
    test_div;
    test_flush;
    test_move;
    test_reset_mid;
    test_w16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
